// File: rtl/i2s_frame_controller_if.sv
// Downstream stereo-frame handshake between the I2S frame controller and its consumer.
interface i2s_frame_controller_if;
  logic frame_valid;
  logic frame_ready;
  logic overrun;

  modport master (output frame_valid, output overrun, input frame_ready);
  modport slave  (input frame_valid, input overrun, output frame_ready);
endinterface

// File: rtl/i2s_frame_controller.sv
// I2S timing master: divides mclk into sclk/ws, issues shift and latch strobes
// to the receiver datapath and hands completed stereo frames downstream.
module i2s_frame_controller #(
    parameter int WIDTH    = 16,
    parameter int SLOT     = 32,
    parameter int SCLK_DIV = 8,
    parameter int DELAY    = 0
) (
    input  logic                     mclk,
    input  logic                     rst,
    input  logic                     en,
    output logic                     sclk,
    output logic                     ws,
    output logic                     shift_en,
    output logic [$clog2(WIDTH)-1:0] bit_idx,
    output logic                     latch_l,
    output logic                     latch_r,
    i2s_frame_controller_if.master   frame,
    output logic                     busy
);

    localparam int DW = $clog2(SCLK_DIV);
    localparam int BW = $clog2(SLOT);
    localparam int IW = $clog2(WIDTH);

    localparam logic [DW-1:0] DIV_LAST  = DW'(SCLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF  = DW'(SCLK_DIV / 2);
    localparam logic [DW-1:0] DIV_LATCH = DW'(SCLK_DIV / 2 + 1);
    localparam logic [BW-1:0] SLOT_LAST = BW'(SLOT - 1);
    localparam logic [BW-1:0] BIT_FIRST = BW'(DELAY);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DELAY + WIDTH - 1);
    localparam logic [BW-1:0] MSB_IDX   = BW'(WIDTH - 1);
    localparam logic [BW:0]   WIN_LEN   = (BW + 1)'(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

    state_t        state, state_n;
    logic [DW-1:0] div_cnt, div_n;
    logic [BW-1:0] bit_cnt, bit_n;
    logic          ws_n;
    logic          frame_end;
    logic [BW-1:0] win_off;
    logic          in_win;
    logic          latch_pt;

    always_ff @(posedge mclk) begin
        if (!rst) begin
            state             <= IDLE;
            div_cnt           <= '0;
            bit_cnt           <= '0;
            ws                <= 1'b0;
            sclk              <= 1'b0;
            frame.frame_valid <= 1'b0;
            frame.overrun     <= 1'b0;
        end else begin
            state   <= state_n;
            div_cnt <= div_n;
            bit_cnt <= bit_n;
            ws      <= ws_n;
            // registered from the next count so sclk lines up with div_cnt
            sclk    <= (div_n >= DIV_HALF);
            if (latch_r) begin
                frame.frame_valid <= 1'b1;
                frame.overrun     <= frame.frame_valid & ~frame.frame_ready;
            end else begin
                frame.overrun <= 1'b0;
                if (frame.frame_valid && frame.frame_ready)
                    frame.frame_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        state_n   = state;
        div_n     = div_cnt;
        bit_n     = bit_cnt;
        ws_n      = ws;
        frame_end = ws && (bit_cnt == SLOT_LAST) && (div_cnt == DIV_LAST);

        if (state == IDLE) begin
            div_n = '0;
            bit_n = '0;
            ws_n  = 1'b0;
            if (en)
                state_n = RUN;
        end else begin
            if (div_cnt == DIV_LAST) begin
                div_n = '0;
                if (bit_cnt == SLOT_LAST) begin
                    bit_n = '0;
                    ws_n  = ~ws;
                end else begin
                    bit_n = bit_cnt + BW'(1);
                end
            end else begin
                div_n = div_cnt + DW'(1);
            end

            // the natural frame wrap already zeroes counters and ws on the way to IDLE
            if (state == RUN) begin
                if (!en)
                    state_n = STOP;
            end else if (en) begin
                state_n = RUN;
            end else if (frame_end) begin
                state_n = IDLE;
            end
        end
    end

    // offset wraps to a large value below DELAY, so one compare covers both window edges
    assign win_off  = bit_cnt - BIT_FIRST;
    assign in_win   = ({1'b0, win_off} < WIN_LEN);
    assign busy     = (state != IDLE);
    assign shift_en = busy && (div_cnt == DIV_HALF) && in_win;
    assign bit_idx  = shift_en ? IW'(MSB_IDX - win_off) : '0;
    assign latch_pt = busy && (div_cnt == DIV_LATCH) && (bit_cnt == BIT_LAST);
    assign latch_l  = latch_pt && !ws;
    assign latch_r  = latch_pt && ws;

endmodule

// File: tb/tb_i2s_frame_controller.sv
// Directed bench for i2s_frame_controller: strobe events are scoreboarded,
// frame-level outputs are checked at fixed cycles.
module tb_i2s_frame_controller;

    localparam int W   = 16;
    localparam int SLT = 32;
    localparam int DIV = 8;

    typedef struct {
        int kind;  // 0 shift, 1 latch_l, 2 latch_r, 3 overrun
        int cyc;
        int idx;
    } ev_t;

    logic mclk = 1'b0;
    always #5 mclk = ~mclk;

    logic rst0, rst1, en, ready, sel;
    logic sclk0, ws0, sh0, ll0, lr0, busy0;
    logic sclk1, ws1, sh1, ll1, lr1, busy1;
    logic [3:0] idx0, idx1;

    i2s_frame_controller_if f0();
    i2s_frame_controller_if f1();
    assign f0.frame_ready = ready;
    assign f1.frame_ready = ready;

    i2s_frame_controller dut0 (
        .mclk(mclk), .rst(rst0), .en(en), .sclk(sclk0), .ws(ws0), .shift_en(sh0),
        .bit_idx(idx0), .latch_l(ll0), .latch_r(lr0), .frame(f0), .busy(busy0)
    );

    i2s_frame_controller #(.DELAY(1)) dut1 (
        .mclk(mclk), .rst(rst1), .en(en), .sclk(sclk1), .ws(ws1), .shift_en(sh1),
        .bit_idx(idx1), .latch_l(ll1), .latch_r(lr1), .frame(f1), .busy(busy1)
    );

    logic       m_sclk, m_ws, m_sh, m_ll, m_lr, m_fv, m_ov, m_busy;
    logic [3:0] m_idx;
    logic [11:0] obs;
    assign m_sclk = sel ? sclk1 : sclk0;
    assign m_ws   = sel ? ws1   : ws0;
    assign m_sh   = sel ? sh1   : sh0;
    assign m_idx  = sel ? idx1  : idx0;
    assign m_ll   = sel ? ll1   : ll0;
    assign m_lr   = sel ? lr1   : lr0;
    assign m_fv   = sel ? f1.frame_valid : f0.frame_valid;
    assign m_ov   = sel ? f1.overrun     : f0.overrun;
    assign m_busy = sel ? busy1 : busy0;
    assign obs = {m_sclk, m_ws, m_sh, m_idx, m_ll, m_lr, m_fv, m_ov, m_busy};

    int  cyc = 0;
    int  t0 = 0;
    int  n_checks = 0;
    int  n_err = 0;
    ev_t exp_q[$];

    always @(posedge mclk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc - t0);
        end
    endtask

    task automatic push_ev(input int kind, input int c, input int idx, input int limit);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.idx  = idx;
        if (c < limit) exp_q.push_back(e);
    endtask

    // expected strobes of one stereo frame starting at cycle 'base'
    task automatic push_frame(input int base, input int dly, input int limit);
        for (int ch = 0; ch < 2; ch++) begin
            for (int n = 0; n < W; n++)
                push_ev(0, base + ch * SLT * DIV + (dly + n) * DIV + DIV / 2, W - 1 - n, limit);
            push_ev(1 + ch, base + ch * SLT * DIV + (dly + W - 1) * DIV + DIV / 2 + 1, 0, limit);
        end
    endtask

    task automatic start();
        en = 1'b1;
        t0 = cyc + 1;
    endtask

    task automatic wait_rel(input int n);
        while ((cyc - t0) < n) @(negedge mclk);
    endtask

    task automatic end_test();
        if (sel) rst1 = 1'b0; else rst0 = 1'b0;
        en = 1'b0;
        @(negedge mclk);
        chk("abort_outputs", {20'd0, obs}, 32'd0);
        @(negedge mclk);
        if (sel) rst1 = 1'b1; else rst0 = 1'b1;
        chk("missing_events", exp_q.size(), 32'd0);
    endtask

    // scoreboard: every strobe the DUT emits must match the next expected event
    always @(negedge mclk) begin
        logic [3:0] hits;
        ev_t e;
        hits = {m_ov, m_lr, m_ll, m_sh};
        for (int k = 0; k < 4; k++) begin
            if (hits[k]) begin
                n_checks++;
                assert (exp_q.size() > 0) else begin
                    n_err++;
                    $error("FAIL unexpected_event: kind %0d at cycle %0d, expected none", k, cyc - t0);
                end
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    n_checks++;
                    assert ({k, cyc - t0, 32'(m_idx)} === {e.kind, e.cyc, e.idx}) else begin
                        n_err++;
                        $error("FAIL event: got kind %0d cycle %0d idx %0d, expected kind %0d cycle %0d idx %0d",
                               k, cyc - t0, m_idx, e.kind, e.cyc, e.idx);
                    end
                end
            end
        end
    end

    initial begin
        rst0 = 1'b0; rst1 = 1'b0; en = 1'b0; ready = 1'b1; sel = 1'b0;

        // reset and idle
        repeat (4) begin
            @(negedge mclk);
            chk("reset_outputs", {20'd0, obs}, 32'd0);
        end
        rst0 = 1'b1;
        repeat (100) begin
            @(negedge mclk);
            chk("idle_outputs", {20'd0, obs}, 32'd0);
        end

        // basic frames, downstream always ready
        push_frame(0, 0, 1 << 30);
        push_frame(512, 0, 1 << 30);
        start();
        wait_rel(0);   chk("busy_c0", m_busy, 1);
        wait_rel(3);   chk("sclk_c3", m_sclk, 0);
        wait_rel(4);   chk("sclk_c4", m_sclk, 1);
        wait_rel(255); chk("ws_c255", m_ws, 0);
        wait_rel(256); chk("ws_c256", m_ws, 1);
        wait_rel(381); chk("fv_c381", m_fv, 0);
        wait_rel(382); chk("fv_c382", m_fv, 1);
        wait_rel(383); chk("fv_c383", m_fv, 0);
        wait_rel(512); chk("ws_c512", m_ws, 0);
        wait_rel(893); chk("fv_c893", m_fv, 0);
        wait_rel(894); chk("fv_c894", m_fv, 1);
        wait_rel(895); chk("fv_c895", m_fv, 0);
        wait_rel(1024);
        end_test();

        // backpressure across two frames
        ready = 1'b0;
        push_frame(0, 0, 1 << 30);
        push_frame(512, 0, 1 << 30);
        push_ev(3, 894, 0, 1 << 30);
        start();
        wait_rel(381); chk("bp_fv_c381", m_fv, 0);
        wait_rel(382); chk("bp_fv_c382", m_fv, 1);
        wait_rel(600); chk("bp_fv_c600", m_fv, 1);
        wait_rel(894); chk("bp_fv_c894", m_fv, 1);
        wait_rel(900); chk("bp_fv_c900", m_fv, 1);
        ready = 1'b1;
        wait_rel(901); chk("bp_fv_c901", m_fv, 0);
        wait_rel(1024);
        end_test();

        // graceful stop mid-frame
        push_frame(0, 0, 1 << 30);
        start();
        wait_rel(200); en = 1'b0;
        wait_rel(300); chk("stop_busy_c300", m_busy, 1);
        wait_rel(382); chk("stop_fv_c382", m_fv, 1);
        wait_rel(511); chk("stop_busy_c511", m_busy, 1);
        wait_rel(512); chk("stop_idle_c512", {m_busy, m_sclk, m_ws}, 0);
        wait_rel(700); chk("stop_busy_c700", m_busy, 0);
        end_test();

        // stop then restart before frame end
        push_frame(0, 0, 1 << 30);
        push_frame(512, 0, 1 << 30);
        start();
        wait_rel(200); en = 1'b0;
        wait_rel(300); en = 1'b1;
        wait_rel(512); chk("restart_busy_c512", m_busy, 1);
        wait_rel(1024);
        end_test();

        // reset mid-frame aborts without latches
        push_frame(0, 0, 151);
        start();
        wait_rel(150); rst0 = 1'b0; en = 1'b0;
        wait_rel(151); chk("abort_c151", {20'd0, obs}, 32'd0);
        wait_rel(152); rst0 = 1'b1;
        wait_rel(550); chk("abort_idle_c550", {20'd0, obs}, 32'd0);
        end_test();

        // Philips alignment on the DELAY=1 instance
        sel = 1'b1;
        rst1 = 1'b1;
        @(negedge mclk);
        push_frame(0, 1, 1 << 30);
        start();
        wait_rel(389); chk("d1_fv_c389", m_fv, 0);
        wait_rel(390); chk("d1_fv_c390", m_fv, 1);
        wait_rel(512);
        end_test();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/i2s_frame_controller.md
Name: i2s_frame_controller

Overview:
- Timing master for the I2S audio front end.
- Divides mclk into the serial bit clock (sclk) and word select (ws).
- Issues per-bit shift strobes and per-channel latch strobes to the I2S receiver datapath.
- Hands completed stereo frames downstream over a valid/ready handshake, with start/stop sequencing and overrun detection.

Parameters:
- WIDTH, 16: audio data bits per channel.
- SLOT, 32: sclk periods per channel slot. Frame length = 2*SLOT.
- SCLK_DIV, 8: mclk cycles per sclk period. Must be even and >= 4.
- DELAY, 0: sclk periods between a ws edge and the MSB. 0 = left-justified, 1 = Philips I2S. Requires DELAY+WIDTH <= SLOT.

Ports:
- mclk  in  1  system/master clock; all logic on its rising edge.
- rst  in  1  synchronous, active-low reset.
- en  in  1  run request.
- sclk  out  1  serial bit clock, registered.
- ws  out  1  word select, registered; 0 = left, 1 = right.
- shift_en  out  1  one-mclk pulse: receiver samples sd_rx this cycle.
- bit_idx  out  $clog2(WIDTH)  destination bit of current shift (MSB first).
- latch_l  out  1  one-mclk pulse: left word complete.
- latch_r  out  1  one-mclk pulse: right word complete.
- frame_valid  out  1  stereo frame available downstream.
- frame_ready  in  1  downstream accepts frame.
- overrun  out  1  one-mclk pulse: frame completed while the previous one was still unaccepted.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst=0 at a mclk edge): state=IDLE; div_cnt=0, bit_cnt=0. All outputs 0: sclk, ws, shift_en, bit_idx, latch_l, latch_r, frame_valid, overrun, busy. Reset asserted mid-frame aborts immediately; no partial latch is issued.
- States: IDLE, RUN, STOP.
  - IDLE: counters held at 0, sclk=0, ws=0. en=1 -> RUN next cycle.
  - RUN: en=0 -> STOP.
  - STOP: counters keep running. en=1 -> RUN with no timing discontinuity. At end of frame (ws=1, bit_cnt=SLOT-1, div_cnt=SCLK_DIV-1) -> IDLE next cycle, counters/sclk/ws zeroed.
  - RUN and STOP behave identically except for this termination.
- div_cnt: counts 0..SCLK_DIV-1 and wraps.
  - sclk = 1 when div_cnt >= SCLK_DIV/2, else 0; registered, aligned with div_cnt.
- bit_cnt: increments when div_cnt wraps (sclk falling edge), range 0..SLOT-1.
  - On SLOT-1 -> 0 wrap, ws toggles in the same cycle.
- Cycle numbering: cycle 0 = first RUN cycle (div_cnt=0, bit_cnt=0, ws=0).
- shift_en = 1 when div_cnt == SCLK_DIV/2 and DELAY <= bit_cnt < DELAY+WIDTH.
  - bit_idx = WIDTH-1-(bit_cnt-DELAY) during shift_en; otherwise 0.
  - No shifts in padding bits.
- latch_l / latch_r = 1 when div_cnt == SCLK_DIV/2+1 and bit_cnt == DELAY+WIDTH-1; selected by current ws (0 -> latch_l, 1 -> latch_r).
- frame_valid:
  - set the cycle after latch_r;
  - cleared the cycle after frame_valid && frame_ready.
  - Set and accept in the same cycle -> stays 1, no overrun.
  - latch_r with frame_valid=1 and frame_ready=0 -> overrun pulses 1 cycle in the frame_valid set cycle; frame_valid stays 1.
- STOP still completes the right slot and may set frame_valid.
- Nothing is launched from IDLE.
- Latency at defaults: frame = 512 mclk. First shift at cycle 4. latch_l at 125. ws rises at 256. latch_r at 381. frame_valid at 382.

Test Plan:
- Reset/idle: rst=0 for 4 cycles, then rst=1, en=0 for 100 cycles -> every output 0, busy=0, sclk never toggles.
- Basic frame (defaults, frame_ready=1, en held 1):
  - shift_en at cycles 4+8n, n=0..15, with bit_idx 15..0;
  - latch_l at 125; ws=1 from 256; latch_r at 381;
  - frame_valid high exactly cycle 382; repeats every 512 cycles.
- Backpressure: frame_ready=0 for two frames -> frame_valid=1 from 382; overrun pulses once at 894. frame_ready=1 at 900 -> frame_valid low at 901.
- Graceful stop: drop en at cycle 200 -> busy stays 1, latch_r at 381, frame_valid at 382, IDLE (busy=0, sclk=0, ws=0) at cycle 512, no further shift_en.
- Stop/restart: drop en at 200, raise at 300 -> no gap; shift_en at 512+4 continues the normal cadence.
- Abort and DELAY=1: rst=0 at cycle 150 -> all outputs 0 at next edge, no latch_l/latch_r. Rerun with DELAY=1 -> first shift_en at 12, latch_l at 133.
